// File: rtl/qam16_symbol_mapper.sv
// QAM16 symbol mapper: input FIFO, Gray-coded I/Q mapping and a valid/ready output register.
// Optional pilot insertion every PILOT_PERIOD data symbols when QAM16_PILOT_EN is defined.
module qam16_symbol_mapper #(
  parameter int unsigned OUT_W        = 16,
  parameter int unsigned AMP_UNIT     = 2048,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PILOT_PERIOD = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              sym_in,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  output logic signed [OUT_W-1:0] i_out,
  output logic signed [OUT_W-1:0] q_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    pilot_flag,
  output logic                    overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef logic signed [OUT_W-1:0] amp_t;

  localparam amp_t AmpP1 = amp_t'(AMP_UNIT);
  localparam amp_t AmpP3 = amp_t'(3 * AMP_UNIT);

  function automatic amp_t gray_level(input logic [1:0] bits);
    amp_t lvl;
    case (bits)
      2'b00:   lvl = -AmpP3;
      2'b01:   lvl = -AmpP1;
      2'b11:   lvl = AmpP1;
      default: lvl = AmpP3;
    endcase
    return lvl;
  endfunction

  logic [3:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  amp_t            i_q, i_d;
  amp_t            q_q, q_d;
  logic            valid_q, valid_d;
  logic            pilot_q, pilot_d;
  logic            ovf_q, ovf_d;

  logic full, empty, push, pop, can_load, load_data, load_pilot;

  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push     = sym_valid && !full;
  assign can_load = !valid_q || out_ready;
  assign pop      = load_data;

`ifdef QAM16_PILOT_EN
  localparam int unsigned PcW = (PILOT_PERIOD > 1) ? $clog2(PILOT_PERIOD) : 1;

  typedef enum logic {StData, StPilot} state_e;

  state_e         state_q, state_d;
  logic [PcW-1:0] pcnt_q, pcnt_d;

  always_comb begin
    load_data  = 1'b0;
    load_pilot = 1'b0;
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    unique case (state_q)
      StData: begin
        if (can_load && !empty) begin
          load_data = 1'b1;
          if (pcnt_q == PcW'(PILOT_PERIOD - 1)) begin
            state_d = StPilot;
            pcnt_d  = '0;
          end else begin
            pcnt_d = pcnt_q + PcW'(1);
          end
        end
      end
      StPilot: begin
        // Pilot needs only a free output slot, never FIFO data.
        if (can_load) begin
          load_pilot = 1'b1;
          state_d    = StData;
        end
      end
      default: state_d = StData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StData;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  // Pilot period only matters when pilots are built in.
  logic unused_pilot_period;
  assign unused_pilot_period = ^PILOT_PERIOD;
  assign load_data  = can_load && !empty;
  assign load_pilot = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    ovf_d   = ovf_q || (sym_valid && full);
    i_d     = i_q;
    q_d     = q_q;
    pilot_d = pilot_q;
    valid_d = valid_q;
    if (load_pilot) begin
      i_d     = AmpP3;
      q_d     = AmpP3;
      pilot_d = 1'b1;
      valid_d = 1'b1;
    end else if (load_data) begin
      i_d     = gray_level(mem_q[rd_ptr_q][3:2]);
      q_d     = gray_level(mem_q[rd_ptr_q][1:0]);
      pilot_d = 1'b0;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sym_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      i_q      <= '0;
      q_q      <= '0;
      valid_q  <= 1'b0;
      pilot_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      i_q      <= i_d;
      q_q      <= q_d;
      valid_q  <= valid_d;
      pilot_q  <= pilot_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sym_ready  = !full;
  assign i_out      = i_q;
  assign q_out      = q_q;
  assign out_valid  = valid_q;
  assign pilot_flag = pilot_q;
  assign overflow   = ovf_q;

endmodule
